uart_tx: RTL

UART transmit serializer, directly downstream of the baud-rate generator. It accepts one byte per valid/ready handshake and shifts out an asynchronous frame on `tx`: start bit, 8 data bits LSB-first, optional parity, then 1 or 2 stop bits. Bit boundaries are paced by a single-cycle `baud_tick` strobe from the baud-rate generator. The whole block runs on the system clock.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_tx.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM encoding, parity-mode codes and parity helpers.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } uart_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  // Odd mode inverts the plain XOR so the total count of ones becomes odd.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic [1:0] mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmit serializer: start bit, 8 data bits LSB-first, optional parity,
// 1 or 2 stop bits, with every bit boundary paced by baud_tick.
module uart_tx
  import uart_pkg::*;
#(
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_tick,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic [1:0] parity_mode,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [1:0]  mode_q, mode_d;
  logic        par_q, par_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        stop_cnt_q, stop_cnt_d;
  logic        tx_q, tx_d;
  logic        ready_q;
  logic        busy_q;
  logic        done_q, done_d;
  logic        accept_s;

  assign accept_s = tx_valid && ready_q;

  // Next-state and next-output logic for the frame FSM.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    mode_d     = mode_q;
    par_d      = par_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (accept_s) begin
          shift_d = tx_data;
          mode_d  = parity_mode;
          par_d   = parity_bit(tx_data, parity_mode);
          // A tick on the accept edge starts the frame at once, skipping SYNC.
          if (baud_tick) begin
            state_d = ST_START;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_SYNC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SYNC: begin
        if (baud_tick) begin
          state_d = ST_START;
          tx_d    = 1'b0;
        end else begin
          tx_d = 1'b1;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          state_d   = ST_DATA;
          tx_d      = shift_q[0];
          bit_cnt_d = 3'd0;
        end else begin
          tx_d = 1'b0;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q != LAST_BIT) begin
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else if (parity_enabled(mode_q)) begin
            state_d = ST_PARITY;
            tx_d    = par_q;
          end else begin
            state_d    = ST_STOP;
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
          end
        end else begin
          tx_d = tx_q;
        end
      end
      ST_PARITY: begin
        if (baud_tick) begin
          state_d    = ST_STOP;
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end else begin
          tx_d = par_q;
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (baud_tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end else begin
          stop_cnt_d = stop_cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State and registered outputs; ready/busy are decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= 8'h00;
      mode_q     <= PAR_NONE;
      par_q      <= 1'b0;
      bit_cnt_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      mode_q     <= mode_d;
      par_q      <= par_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      ready_q    <= (state_d == ST_IDLE);
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= done_d;
    end
  end

  assign tx_ready = ready_q;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign tx_done  = done_q;

endmodule
